pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards and branch-taken flushes, drains the pipeline on a decoded HALT, and gates execution through a run/stop/step debug handshake. It sits beside the decoder and owns every pipeline-register enable and flush in the core.

## Interface
- `DRAIN_CYCLES`, default 4: bubbles inserted after HALT before reporting halted (≥1).
- `CNT_BITS`, default 16: width of the stall-cycle counter.

Ports:
- `i_clk`  in  1  single core clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_IDEX_MemRead`  in  1  instruction in EX is a load.
- `i_IDEX_Rt`  in  5  load destination register in EX.
- `i_IFID_Rs`, `i_IFID_Rt`  in  5 each  source registers of the instruction in ID.
- `i_BranchTaken`  in  1  branch resolved taken in MEM.
- `i_Halt`  in  1  HALT decoded in ID.
- `i_DbgRun`, `i_DbgStop`, `i_DbgStep`  in  1 each  debug commands, single-cycle pulses.
- `o_PCWrite`  out  1  PC load enable.
- `o_IFID_Write`  out  1  IF/ID load enable.
- `o_IFID_Flush`, `o_IDEX_Flush`, `o_EXMEM_Flush`  out  1 each  load a bubble into the named register (all control bits 0).
- `o_PipeEn`  out  1  global enable for ID/EX, EX/MEM, MEM/WB, data-memory write and register-file write.
- `o_Halted`  out  1  pipeline drained after HALT.
- `o_StepDone`  out  1  one-cycle pulse when a step completes.
- `o_StallCount`  out  CNT_BITS  saturating count of load-use stall cycles.

## Operation
States: IDLE, RUN, STEP, DRAIN, HALTED. The state after reset is IDLE.

- **Frozen behaviour (IDLE, HALTED):** all enables are 0 and all flushes are 0, so every register holds its value.
- **Active behaviour (RUN, STEP):** all enables are 1 by default. Overrides are applied in priority order:
  1. Branch: when `i_BranchTaken`=1, assert IF/ID, ID/EX and EX/MEM flush; PC stays enabled to load the target.
  2. Load-use: when `i_IDEX_MemRead`=1, `i_IDEX_Rt`≠0, and `i_IDEX_Rt` equals `i_IFID_Rs` or `i_IFID_Rt`, drive `o_PCWrite`=0, `o_IFID_Write`=0, `o_IDEX_Flush`=1 and `o_PipeEn`=1. The stall counter increments.
- **DRAIN behaviour:** `o_PCWrite`=0, `o_IFID_Flush`=1, `o_PipeEn`=1. The load-use check is not performed.

Transitions:
- IDLE→RUN on `i_DbgRun`. IDLE→STEP on `i_DbgStep` when the macro is enabled. `i_DbgRun` wins if both arrive together.
- RUN→IDLE on `i_DbgStop`.
- RUN→DRAIN on `i_Halt` when no branch is taken and no load-use stall occurs that cycle. `i_Halt` has priority over `i_DbgStop`.
- STEP→IDLE unconditionally after one cycle, with `o_StepDone`=1 during that cycle. `i_Halt` seen during STEP goes to DRAIN instead, and `o_StepDone` still pulses.
- DRAIN:
  - The counter loads DRAIN_CYCLES−1 on entry and decrements each cycle; at 0 the controller goes to HALTED.
  - If `i_BranchTaken`=1 during DRAIN, the HALT was on the wrong path: apply the branch flushes with PC enabled and return to RUN.
  - `i_DbgStop` is ignored in DRAIN.
- HALTED is left only by reset. `o_Halted`=1 while in HALTED.

Stall counter: increments once per load-use stall cycle and saturates at 2^CNT_BITS−1.

## Timing
- Hazard and flush outputs are combinational from the current state and inputs, so they act in the same cycle as the detect. The state and counters are registered.
- Reset values: state IDLE, all enables 0, all flushes 0, `o_Halted`=0, `o_StepDone`=0, `o_StallCount`=0, drain counter 0.
- Assertion of `i_rst_n` mid-DRAIN or mid-STEP aborts immediately to the reset values.
- `o_Halted` rises exactly DRAIN_CYCLES cycles after the cycle in which `i_Halt` was accepted.
- A debug command arriving in a state that does not accept it is dropped, not queued.
- A load-use stall lasts one cycle: in the next cycle the load has moved to MEM and `i_IDEX_MemRead` reflects the bubble.

## Configuration
- `PIPE_CTRL_STEP_EN`, when defined: the STEP state and `i_DbgStep` handling are compiled in.
- When undefined: the STEP state is removed, `i_DbgStep` is ignored, and `o_StepDone` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then pulse `i_DbgRun`: the outputs hold the frozen values until the run pulse, then `o_PCWrite`=`o_IFID_Write`=`o_PipeEn`=1 in the following cycle.
- RUN with `i_IDEX_MemRead`=1, `i_IDEX_Rt`=5, `i_IFID_Rs`=5: for one cycle `o_PCWrite`=0, `o_IFID_Write`=0, `o_IDEX_Flush`=1, and `o_StallCount` goes 0→1. Repeating the same inputs with Rt=0 produces no stall.
- Same cycle with load-use match and `i_BranchTaken`=1: all three flushes are 1, `o_PCWrite`=1, and `o_StallCount` is unchanged.
- `i_Halt` in RUN with DRAIN_CYCLES=4: `o_PCWrite`=0 and `o_IFID_Flush`=1 for 4 cycles, then `o_Halted`=1 and stays 1; a subsequent `i_DbgRun` has no effect.
- `i_BranchTaken` in the second DRAIN cycle: the flushes assert, the controller returns to RUN, and `o_Halted` never asserts.
- With `PIPE_CTRL_STEP_EN`: from IDLE, an `i_DbgStep` pulse gives exactly one active cycle with `o_StepDone`=1, then the controller returns to frozen. Without the macro, the same pulse leaves the outputs frozen and `o_StepDone`=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: enables, flushes, load-use stall, HALT drain and run/stop/step debug.
// Optional single-step support is compiled in when PIPE_CTRL_STEP_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_BITS     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_IDEX_MemRead,
    input  logic [4:0]          i_IDEX_Rt,
    input  logic [4:0]          i_IFID_Rs,
    input  logic [4:0]          i_IFID_Rt,
    input  logic                i_BranchTaken,
    input  logic                i_Halt,
    input  logic                i_DbgRun,
    input  logic                i_DbgStop,
    input  logic                i_DbgStep,
    output logic                o_PCWrite,
    output logic                o_IFID_Write,
    output logic                o_IFID_Flush,
    output logic                o_IDEX_Flush,
    output logic                o_EXMEM_Flush,
    output logic                o_PipeEn,
    output logic                o_Halted,
    output logic                o_StepDone,
    output logic [CNT_BITS-1:0] o_StallCount
);

    localparam int unsigned     DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
`ifdef PIPE_CTRL_STEP_EN
        STEP,
`endif
        DRAIN,
        HALTED
    } state_t;

    state_t              state, state_next;
    logic [DW-1:0]       drain_cnt;
    logic [CNT_BITS-1:0] stall_cnt;
    logic                load_use;
    logic                active;
    logic                halt_ok;
    logic                stall;

`ifndef PIPE_CTRL_STEP_EN
    logic unused_dbg_step;
    assign unused_dbg_step = i_DbgStep;
`endif

    assign load_use = i_IDEX_MemRead && (i_IDEX_Rt != '0) &&
                      ((i_IDEX_Rt == i_IFID_Rs) || (i_IDEX_Rt == i_IFID_Rt));
    assign halt_ok  = i_Halt && !i_BranchTaken && !load_use;

    always_comb begin
        state_next    = state;
        o_PCWrite     = 1'b0;
        o_IFID_Write  = 1'b0;
        o_IFID_Flush  = 1'b0;
        o_IDEX_Flush  = 1'b0;
        o_EXMEM_Flush = 1'b0;
        o_PipeEn      = 1'b0;
        o_Halted      = 1'b0;
        o_StepDone    = 1'b0;
        stall         = 1'b0;

`ifdef PIPE_CTRL_STEP_EN
        active = (state == RUN) || (state == STEP);
`else
        active = (state == RUN);
`endif

        if (active) begin
            o_PCWrite    = 1'b1;
            o_IFID_Write = 1'b1;
            o_PipeEn     = 1'b1;
            // A taken branch squashes the dependent instruction, so no stall is needed
            if (i_BranchTaken) begin
                o_IFID_Flush  = 1'b1;
                o_IDEX_Flush  = 1'b1;
                o_EXMEM_Flush = 1'b1;
            end else if (load_use) begin
                o_PCWrite    = 1'b0;
                o_IFID_Write = 1'b0;
                o_IDEX_Flush = 1'b1;
                stall        = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (i_DbgRun)
                    state_next = RUN;
`ifdef PIPE_CTRL_STEP_EN
                else if (i_DbgStep)
                    state_next = STEP;
`endif
            end
            RUN: begin
                if (halt_ok)
                    state_next = DRAIN;
                else if (i_DbgStop)
                    state_next = IDLE;
            end
`ifdef PIPE_CTRL_STEP_EN
            STEP: begin
                o_StepDone = 1'b1;
                state_next = halt_ok ? DRAIN : IDLE;
            end
`endif
            DRAIN: begin
                o_IFID_Write = 1'b1;
                o_IFID_Flush = 1'b1;
                o_PipeEn     = 1'b1;
                // HALT came from the wrong path: flush it away and resume
                if (i_BranchTaken) begin
                    o_PCWrite     = 1'b1;
                    o_IDEX_Flush  = 1'b1;
                    o_EXMEM_Flush = 1'b1;
                    state_next    = RUN;
                end else if (drain_cnt == '0) begin
                    state_next = HALTED;
                end
            end
            HALTED: o_Halted = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (state != DRAIN && state_next == DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DW'(1);
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_BITS'(1);
        end
    end

    assign o_StallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (small stall counter to reach saturation).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_BITS = 3;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_IDEX_MemRead;
    logic [4:0]          i_IDEX_Rt;
    logic [4:0]          i_IFID_Rs;
    logic [4:0]          i_IFID_Rt;
    logic                i_BranchTaken;
    logic                i_Halt;
    logic                i_DbgRun;
    logic                i_DbgStop;
    logic                i_DbgStep;
    logic                o_PCWrite;
    logic                o_IFID_Write;
    logic                o_IFID_Flush;
    logic                o_IDEX_Flush;
    logic                o_EXMEM_Flush;
    logic                o_PipeEn;
    logic                o_Halted;
    logic                o_StepDone;
    logic [CNT_BITS-1:0] o_StallCount;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (4),
        .CNT_BITS     (CNT_BITS)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_IDEX_MemRead (i_IDEX_MemRead),
        .i_IDEX_Rt      (i_IDEX_Rt),
        .i_IFID_Rs      (i_IFID_Rs),
        .i_IFID_Rt      (i_IFID_Rt),
        .i_BranchTaken  (i_BranchTaken),
        .i_Halt         (i_Halt),
        .i_DbgRun       (i_DbgRun),
        .i_DbgStop      (i_DbgStop),
        .i_DbgStep      (i_DbgStep),
        .o_PCWrite      (o_PCWrite),
        .o_IFID_Write   (o_IFID_Write),
        .o_IFID_Flush   (o_IFID_Flush),
        .o_IDEX_Flush   (o_IDEX_Flush),
        .o_EXMEM_Flush  (o_EXMEM_Flush),
        .o_PipeEn       (o_PipeEn),
        .o_Halted       (o_Halted),
        .o_StepDone     (o_StepDone),
        .o_StallCount   (o_StallCount)
    );

    always #5 i_clk = ~i_clk;

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PipeEn, Halted, StepDone}
    function automatic logic [7:0] outs();
        return {o_PCWrite, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush,
                o_EXMEM_Flush, o_PipeEn, o_Halted, o_StepDone};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    localparam logic [7:0] FROZEN = 8'b0000_0000;
    localparam logic [7:0] ACTIVE = 8'b1100_0100;
    localparam logic [7:0] STALL  = 8'b0001_0100;
    localparam logic [7:0] BRANCH = 8'b1111_1100;
    localparam logic [7:0] HALTD  = 8'b0000_0010;

    initial begin
        i_rst_n = 1'b0;
        i_IDEX_MemRead = 1'b0; i_IDEX_Rt = '0; i_IFID_Rs = '0; i_IFID_Rt = '0;
        i_BranchTaken = 1'b0; i_Halt = 1'b0;
        i_DbgRun = 1'b0; i_DbgStop = 1'b0; i_DbgStep = 1'b0;

        repeat (2) tick();
        check("rst_outs", 32'(outs()), 32'(FROZEN));
        check("rst_cnt", 32'(o_StallCount), 0);
        i_rst_n = 1'b1;
        tick();
        #1 check("idle_frozen", 32'(outs()), 32'(FROZEN));

`ifdef PIPE_CTRL_STEP_EN
        i_DbgStep = 1'b1;
        #1 check("step_pulse_cycle", 32'(outs()), 32'(FROZEN));
        tick();
        i_DbgStep = 1'b0;
        #1 check("step_active", 32'(outs()), 32'(8'b1100_0101));
        tick();
        #1 check("step_back_idle", 32'(outs()), 32'(FROZEN));
`else
        i_DbgStep = 1'b1;
        tick();
        i_DbgStep = 1'b0;
        #1 check("step_ignored", 32'(outs()), 32'(FROZEN));
`endif

        // run
        i_DbgRun = 1'b1;
        #1 check("run_pulse_cycle", 32'(outs()), 32'(FROZEN));
        tick();
        i_DbgRun = 1'b0;
        #1 check("run_active", 32'(outs()), 32'(ACTIVE));

        // load-use on Rs
        i_IDEX_MemRead = 1'b1; i_IDEX_Rt = 5'd5; i_IFID_Rs = 5'd5; i_IFID_Rt = 5'd1;
        #1 check("lu_rs_outs", 32'(outs()), 32'(STALL));
        check("lu_cnt_before", 32'(o_StallCount), 0);
        tick();
        i_IDEX_MemRead = 1'b0;
        #1 check("lu_cnt_after", 32'(o_StallCount), 1);
        check("lu_released", 32'(outs()), 32'(ACTIVE));

        // load-use on Rt
        i_IDEX_MemRead = 1'b1; i_IDEX_Rt = 5'd7; i_IFID_Rs = 5'd3; i_IFID_Rt = 5'd7;
        #1 check("lu_rt_outs", 32'(outs()), 32'(STALL));
        tick();
        i_IDEX_MemRead = 1'b0;
        #1 check("lu_rt_cnt", 32'(o_StallCount), 2);

        // register 0 never stalls
        i_IDEX_MemRead = 1'b1; i_IDEX_Rt = 5'd0; i_IFID_Rs = 5'd0; i_IFID_Rt = 5'd0;
        #1 check("r0_no_stall", 32'(outs()), 32'(ACTIVE));
        tick();
        #1 check("r0_cnt", 32'(o_StallCount), 2);

        // not a load
        i_IDEX_MemRead = 1'b0; i_IDEX_Rt = 5'd5; i_IFID_Rs = 5'd5;
        #1 check("noload_no_stall", 32'(outs()), 32'(ACTIVE));

        // branch beats load-use
        i_IDEX_MemRead = 1'b1; i_BranchTaken = 1'b1;
        #1 check("br_lu_outs", 32'(outs()), 32'(BRANCH));
        tick();
        i_IDEX_MemRead = 1'b0; i_BranchTaken = 1'b0;
        #1 check("br_lu_cnt", 32'(o_StallCount), 2);

        // saturation at 7
        i_IDEX_MemRead = 1'b1;
        repeat (8) tick();
        i_IDEX_MemRead = 1'b0;
        #1 check("cnt_saturate", 32'(o_StallCount), 7);

        // HALT blocked by a stall in the same cycle
        i_Halt = 1'b1; i_IDEX_MemRead = 1'b1;
        tick();
        i_Halt = 1'b0; i_IDEX_MemRead = 1'b0;
        #1 check("halt_blocked", 32'(outs()), 32'(ACTIVE));

        // HALT beats stop; then branch in second DRAIN cycle
        i_Halt = 1'b1; i_DbgStop = 1'b1;
        #1 check("halt_accept_cycle", 32'(outs()), 32'(ACTIVE));
        tick();
        i_Halt = 1'b0;
        i_IDEX_MemRead = 1'b1;
        #1 check("drain1_ctl", 32'({o_PCWrite, o_IFID_Flush, o_PipeEn, o_Halted}), 32'(4'b0110));
        check("drain1_no_lu", 32'(o_IDEX_Flush), 0);
        tick();
        i_DbgStop = 1'b0; i_IDEX_MemRead = 1'b0;
        i_BranchTaken = 1'b1;
        #1 check("drain2_branch", 32'({o_PCWrite, o_IFID_Flush, o_IDEX_Flush, o_EXMEM_Flush, o_Halted}),
                 32'(5'b11110));
        tick();
        i_BranchTaken = 1'b0;
        #1 check("back_to_run", 32'(outs()), 32'(ACTIVE));

        // full drain
        i_Halt = 1'b1;
        tick();
        i_Halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("drain_%0d", i), 32'({o_PCWrite, o_IFID_Flush, o_Halted}), 32'(3'b010));
            tick();
        end
        #1 check("halted", 32'(outs()), 32'(HALTD));
        i_DbgRun = 1'b1;
        tick();
        i_DbgRun = 1'b0;
        #1 check("halted_ignores_run", 32'(outs()), 32'(HALTD));

        // asynchronous reset mid-cycle
        #2 i_rst_n = 1'b0;
        #1 check("async_rst_outs", 32'(outs()), 32'(FROZEN));
        check("async_rst_cnt", 32'(o_StallCount), 0);

        // run then stop
        tick();
        i_rst_n = 1'b1;
        i_DbgRun = 1'b1;
        tick();
        i_DbgRun = 1'b0;
        i_DbgStop = 1'b1;
        tick();
        i_DbgStop = 1'b0;
        #1 check("stop_to_idle", 32'(outs()), 32'(FROZEN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
